// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver: a write opcode byte (bit 7 set) carries a start address,
// and each following byte becomes a one-cycle register write at an auto-incrementing address.
module spi_cmd_rx #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              int_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // Edges are held off until the synchronizers have flushed their reset values, so a CS pin
    // that is already low when reset releases is not mistaken for a new frame start.
    logic                 sck_hist_q;
    logic                 cs_hist_q;
    logic [SYNC_STAGES:0] flush_q;
    logic                 edges_ok;
    logic                 sck_rise_q;
    logic                 cs_rise_q;
    logic                 cs_fall_q;
    logic                 mosi_bit_q;

    assign edges_ok = flush_q[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_hist_q <= 1'b0;
            cs_hist_q  <= 1'b1;
            flush_q    <= '0;
            sck_rise_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            mosi_bit_q <= 1'b0;
        end else begin
            sck_hist_q <= sck_s;
            cs_hist_q  <= cs_s;
            flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            sck_rise_q <= edges_ok & sck_s & ~sck_hist_q & ~cs_s;
            cs_rise_q  <= edges_ok & cs_s & ~cs_hist_q;
            cs_fall_q  <= edges_ok & ~cs_s & cs_hist_q;
            mosi_bit_q <= mosi_s;
        end
    end

    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              int_q;
    logic [7:0]        byte_d;

    assign byte_d = {shift_q, mosi_bit_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            int_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // CS release wins over a coincident SCK edge; a partial byte is dropped here.
            if (cs_rise_q) begin
                if (bit_cnt_q != 3'd0 || state_q == CMD || state_q == ERR) begin
                    int_q <= 1'b1;
                end
                state_q <= IDLE;
            end else if (cs_fall_q && state_q == IDLE) begin
                state_q   <= CMD;
                bit_cnt_q <= 3'd0;
                shift_q   <= 7'd0;
                int_q     <= 1'b0;
            end else if (sck_rise_q && (state_q == CMD || state_q == DATA)) begin
                shift_q   <= byte_d[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == CMD) begin
                        if (byte_d[7]) begin
                            state_q <= DATA;
                            addr_q  <= byte_d[ADDR_W-1:0];
                        end else begin
                            state_q <= ERR;
                        end
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= byte_d;
                        addr_q    <= addr_q + 1'b1;
                    end
                end
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign int_out   = int_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Randomized and directed frames for spi_cmd_rx, checked against a frame-level model.
module tb_spi_cmd_rx;
  localparam int ADDR_W      = 6;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_cs = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              int_out;
  logic [1:0]        dbg_state;

  spi_cmd_rx #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .int_out(int_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard state
  logic [13:0] exp_q[$];
  int          edge_q[$];
  logic [7:0]  frm[$];
  int          n_wr_model;
  logic        exp_err;
  logic [13:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_pending", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e[13:8]);
        check("wr_data", wr_data, mon_e[7:0]);
        if (edge_q.size() > 0) check("wr_latency", cyc - edge_q.pop_front(), SYNC_STAGES + 2);
      end
    end
  end

  // Frame-level reference: decides writes and error purely from the bytes and bit count.
  task automatic model_frame(input int eff);
    int a;
    exp_err    = 1'b0;
    n_wr_model = 0;
    if (eff < 8 || !frm[0][7]) begin
      exp_err = 1'b1;
    end else begin
      n_wr_model = (eff - 8) / 8;
      for (int k = 0; k < n_wr_model; k++) begin
        a = (int'(frm[0][ADDR_W-1:0]) + k) % (1 << ADDR_W);
        exp_q.push_back({a[5:0], frm[k+1]});
      end
      exp_err = ((eff - 8) % 8) != 0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver: one mode-0 bit at SCK = clk/8
  task automatic send_bit(input int i, input bit mark, input bit raise_cs);
    spi_mosi = frm[i/8][7 - (i % 8)];
    wait_clk(4);
    spi_sck = 1'b1;
    if (raise_cs) spi_cs = 1'b1;
    if (mark) edge_q.push_back(cyc);
    wait_clk(4);
    spi_sck = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input bit collide);
    int  eff;
    bit  mark;
    eff = collide ? nbits - 1 : nbits;
    model_frame(eff);
    spi_cs = 1'b0;
    wait_clk(6);
    check("int_clr", int_out, 0);
    for (int i = 0; i < nbits; i++) begin
      mark = !(collide && i == nbits - 1) && (i % 8 == 7) && (i >= 8) && ((i / 8 - 1) < n_wr_model);
      send_bit(i, mark, collide && i == nbits - 1);
    end
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(8);
    check("int_out", int_out, exp_err);
    check("drain", exp_q.size(), 0);
    check("idle", dbg_state, 0);
    exp_q.delete();
    edge_q.delete();
    spi_mosi = 1'b0;
    wait_clk(4);
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_wr_addr"}, wr_addr, 0);
    check({pfx, "_wr_data"}, wr_data, 0);
    check({pfx, "_int"}, int_out, 0);
    check({pfx, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int  nb;
    int  nbits;
    bit  collide;
    logic [7:0] b;

    rst_n = 1'b0;
    wait_clk(3);
    reset_checks("rst");
    rst_n = 1'b1;
    wait_clk(4);

    frm = '{8'h85, 8'hAA, 8'h55}; run_frame(24, 0);
    frm = '{8'hBF, 8'h11, 8'h22}; run_frame(24, 0);
    frm = '{8'h81, 8'hA8};        run_frame(13, 0);
    frm = '{8'h03, 8'hFF};        run_frame(16, 0);
    frm = '{8'hC0};               run_frame(8, 0);
    frm = '{8'h85, 8'h3C};        run_frame(16, 1);

    // reset mid-frame with CS held low, then keep clocking: nothing may be written
    frm = '{8'h82, 8'h77};
    spi_cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 12; i++) send_bit(i, 0, 0);
    rst_n = 1'b0;
    wait_clk(2);
    reset_checks("midrst");
    rst_n = 1'b1;
    wait_clk(2);
    for (int i = 12; i < 16; i++) send_bit(i, 0, 0);
    for (int i = 0; i < 16; i++) send_bit(i, 0, 0);
    wait_clk(4);
    check("midrst_idle", dbg_state, 0);
    spi_cs = 1'b1;
    wait_clk(8);
    check("midrst_noint", int_out, 0);
    frm = '{8'h82, 8'h77};
    run_frame(16, 0);

    for (int f = 0; f < 14; f++) begin
      nb = $urandom_range(1, 4);
      frm.delete();
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        frm.push_back(b);
      end
      b = frm[0];
      if ($urandom_range(0, 3) != 0) b[7] = 1'b1;
      frm[0] = b;
      nbits = 8 * nb;
      if ($urandom_range(0, 2) == 0) nbits = nbits - $urandom_range(1, 7);
      collide = ($urandom_range(0, 5) == 0);
      run_frame(nbits, collide);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    check("timeout", 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_cmd_rx.md
SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, register-address width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per SPI input (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port spi_sck  input  1  SPI clock from the pin, asynchronous to clk.
REQ-006 SHALL have port spi_mosi  input  1  SPI data from the pin, asynchronous to clk.
REQ-007 SHALL have port spi_cs  input  1  SPI chip select from the pin, active-low, asynchronous to clk.
REQ-008 SHALL have port wr_en  output  1  one-cycle write strobe to the GPU register file.
REQ-009 SHALL have port wr_addr  output  ADDR_W  register address, valid when wr_en=1.
REQ-010 SHALL have port wr_data  output  8  register data, valid when wr_en=1.
REQ-011 SHALL have port int_out  output  1  frame-error flag, driven to the interrupt pin.

Function
REQ-012 SHALL pass spi_sck, spi_mosi and spi_cs each through SYNC_STAGES flops clocked by clk before any use.
REQ-013 SHALL detect SCK rising edges from the synchronized SCK plus one history flop; clk SHALL be at least 4x SCK frequency.
REQ-014 SHALL operate in SPI mode 0: MOSI sampled on SCK rising edge, MSB first, 8-bit bytes.
REQ-015 SHALL use FSM states IDLE, CMD, DATA, ERR.
REQ-016 IDLE: on synchronized CS falling edge -> CMD, clear bit counter (3 bits) and shift register.
REQ-017 CMD: after 8th bit, if byte[7]=1 -> DATA with address counter loaded from byte[ADDR_W-1:0]; if byte[7]=0 -> ERR (read and other opcodes unsupported).
REQ-018 DATA: after each 8th bit, SHALL pulse wr_en for exactly one cycle with wr_data=byte and wr_addr=address counter, then increment the address counter.
REQ-019 Address counter SHALL wrap modulo 2^ADDR_W (ADDR_W=6: 63 -> 0) with no error.
REQ-020 wr_en SHALL assert in the clk cycle immediately after the cycle in which the 8th synchronized rising edge is detected; wr_addr/wr_data SHALL hold their values until the next wr_en.
REQ-021 ERR: SHALL ignore all SCK edges until CS deasserts.
REQ-022 Synchronized CS rising edge in any state SHALL -> IDLE; if bit counter != 0 (partial byte), or state was CMD or ERR, int_out SHALL be set.
REQ-023 A partial byte at CS deassertion SHALL be discarded; no wr_en.
REQ-024 Frame with a valid command byte and zero data bytes SHALL end without error and without wr_en.
REQ-025 If the synchronized CS rising edge and an SCK rising edge are detected in the same cycle, CS SHALL take priority and the SCK edge SHALL be ignored.
REQ-026 int_out SHALL stay set until the next synchronized CS falling edge, which clears it.
REQ-027 SCK edges while synchronized CS=1 SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all synchronizers, FSM -> IDLE, bit counter, shift register, address counter, wr_en=0, wr_addr=0, wr_data=0, int_out=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release with CS still low, the block SHALL remain in IDLE until a fresh CS falling edge.
REQ-030 Synchronizer flops SHALL reset to the idle pin levels: sck=0, mosi=0, cs=1.

Verification
REQ-031 Frame 0x85,0xAA,0x55 at SCK=clk/8 -> wr_en pulses twice: (addr 5, 0xAA) then (addr 6, 0x55); int_out=0.
REQ-032 Frame 0xBF,0x11,0x22 -> writes (63, 0x11) then (0, 0x22); wrap, no error.
REQ-033 Frame 0x81 then 5 bits, CS high -> no wr_en; int_out=1; next CS falling edge clears int_out=0.
REQ-034 Frame 0x03,0xFF -> no wr_en; int_out=1 after CS high.
REQ-035 rst_n pulsed low after 4 data bits of frame 0x82,0x77 with CS held low -> no wr_en; all outputs 0; new frame 0x82,0x77 after CS toggle -> single write (2, 0x77).
REQ-036 Latency check: wr_en asserts exactly SYNC_STAGES+2 clk cycles after the 8th raw SCK rising edge when that edge is aligned to clk.
